// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants, coordinate/colour types and a
// window-decode helper used by the VGA sync generator.
package vga_timing_pkg;

  localparam int COORD_W = 10;
  localparam int COLOR_W = 10;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL  = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL  = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
  localparam int HS_START = H_DISPLAY_DEF + H_FRONT_DEF;
  localparam int HS_END   = HS_START + H_SYNC_DEF;
  localparam int VS_START = V_DISPLAY_DEF + V_FRONT_DEF;
  localparam int VS_END   = VS_START + V_SYNC_DEF;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COLOR_W-1:0] color_t;

  // Half-open window test lo <= v < hi on an unsigned coordinate.
  function automatic logic in_span(input coord_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Bundle between the sync generator (master) and the renderer/display side (slave).
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  color_t red_in;
  color_t green_in;
  color_t blue_in;
  coord_t x;
  coord_t y;
  logic   pixel_tick;
  logic   frame_tick;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  color_t vga_r;
  color_t vga_g;
  color_t vga_b;

  modport master (
    input  red_in, green_in, blue_in,
    output x, y, pixel_tick, frame_tick, hsync, vsync, video_on,
           vga_r, vga_g, vga_b
  );

  modport slave (
    output red_in, green_in, blue_in,
    input  x, y, pixel_tick, frame_tick, hsync, vsync, video_on,
           vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/vga_sync_gen_div.sv
// Board-clock to pixel-rate divider: registered one-clock pixel_tick every
// CLK_DIV clocks (continuously high when CLK_DIV is 1).
module pixel_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic pixel_tick_o
);

  localparam logic [2:0] DIV_MAX = 3'(CLK_DIV - 1);

  logic [2:0] div_q, div_d;
  logic       tick_q, tick_d;

  always_comb begin
    div_d  = (div_q == DIV_MAX) ? 3'd0 : div_q + 3'd1;
    tick_d = (div_q == DIV_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= 3'd0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign pixel_tick_o = tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: x/y scan counters, sync/active decode and a one-pixel
// output register that blanks and aligns the renderer's colour with the syncs.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master bus
);

  localparam int HT  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int VT  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HSS = H_DISPLAY + H_FRONT;
  localparam int HSE = HSS + H_SYNC;
  localparam int VSS = V_DISPLAY + V_FRONT;
  localparam int VSE = VSS + V_SYNC;

  localparam coord_t H_LAST = coord_t'(HT - 1);
  localparam coord_t V_LAST = coord_t'(VT - 1);

  logic pixel_tick;

  pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk          (clk),
    .reset        (reset),
    .pixel_tick_o (pixel_tick)
  );

  coord_t x_q, x_d, y_q, y_d;
  logic   hsync_q, hsync_d, vsync_q, vsync_d, von_q, von_d;
  color_t r_q, r_d, g_q, g_d, b_q, b_d;
  logic   end_line, end_frame, act;

  always_comb begin
    end_line  = (x_q == H_LAST);
    end_frame = end_line && (y_q == V_LAST);
    act       = in_span(x_q, 0, H_DISPLAY) && in_span(y_q, 0, V_DISPLAY);

    x_d     = x_q;
    y_d     = y_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    von_d   = von_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;

    // Everything advances on the pixel enable; the output register decodes
    // the coordinate being left, so it trails x/y by exactly one pixel.
    if (pixel_tick) begin
      x_d     = end_line ? '0 : x_q + coord_t'(1);
      y_d     = end_frame ? '0 : (end_line ? y_q + coord_t'(1) : y_q);
      hsync_d = in_span(x_q, HSS, HSE) ? SYNC_POL : ~SYNC_POL;
      vsync_d = in_span(y_q, VSS, VSE) ? SYNC_POL : ~SYNC_POL;
      von_d   = act;
      r_d     = act ? bus.red_in   : '0;
      g_d     = act ? bus.green_in : '0;
      b_d     = act ? bus.blue_in  : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      von_q   <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      von_q   <= von_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.pixel_tick = pixel_tick;
  assign bus.frame_tick = pixel_tick && end_frame;
  assign bus.hsync      = hsync_q;
  assign bus.vsync      = vsync_q;
  assign bus.video_on   = von_q;
  assign bus.vga_r      = r_q;
  assign bus.vga_g      = g_q;
  assign bus.vga_b      = b_q;

endmodule
